traffic_req_gen: RTL and testbench



---
 rtl/traffic_req_gen_pkg.sv | 32 +++
 rtl/traffic_req_gen_lane_filter.sv | 63 ++++++
 rtl/traffic_req_gen.sv | 69 ++++++
 tb/tb_traffic_req_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_req_gen_pkg.sv
// Shared constants for the traffic request front end: controller state
// codes, lane indices and the green-code-to-lane mapping.
package traffic_req_gen_pkg;

    localparam logic [2:0] ST_A_GRN  = 3'b000;
    localparam logic [2:0] ST_A_YEL  = 3'b001;
    localparam logic [2:0] ST_AL_GRN = 3'b010;
    localparam logic [2:0] ST_AL_YEL = 3'b011;
    localparam logic [2:0] ST_B_GRN  = 3'b100;
    localparam logic [2:0] ST_B_YEL  = 3'b101;
    localparam logic [2:0] ST_BL_GRN = 3'b110;
    localparam logic [2:0] ST_BL_YEL = 3'b111;

    localparam int LANE_A  = 0;
    localparam int LANE_AL = 1;
    localparam int LANE_B  = 2;
    localparam int LANE_BL = 3;
    localparam int NUM_LANES = 4;

    // Green code of a lane: lane index in the upper two bits, bit 0 clear.
    function automatic logic [2:0] green_code(input int lane);
        logic [1:0] idx;
        idx = lane[1:0];
        return {idx, 1'b0};
    endfunction

    // Every odd code is a yellow.
    function automatic logic is_yellow(input logic [2:0] st);
        return st[0];
    endfunction

endpackage

// File: rtl/traffic_req_gen_lane_filter.sv
// One detector lane: 2-flop synchronizer, debounce counter and gap timer.
// pres is high while the debounced level is high or the gap hold is running.
module lane_filter
    import traffic_req_gen_pkg::*;
#(
    parameter int unsigned DB_CYC  = 4,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned CW      = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic det,
    output logic pres
);

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC);

    logic [1:0]    sync_reg;
    logic          s;
    logic          deb_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] gap_reg;
    logic          flip;

    assign s    = sync_reg[1];
    // deb changes on this edge: the DB_CYC-th consecutive differing sample.
    assign flip = (s != deb_reg) && (cnt_reg == DB_LAST);

    // Bring the asynchronous detector level into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg <= 2'b00;
        else          sync_reg <= {sync_reg[0], det};
    end

    // Count consecutive disagreeing samples; adopt s once the run is long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (s != deb_reg) begin
            if (flip) begin
                deb_reg <= s;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    // Hold presence for GAP_CYC cycles after the debounced level falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              gap_reg <= '0;
        else if (flip && !s)       gap_reg <= GAP_LOAD;
        else if (flip && s)        gap_reg <= '0;
        else if (gap_reg != '0)    gap_reg <= gap_reg - 1'b1;
    end

    assign pres = deb_reg | (gap_reg != '0);

endmodule

// File: rtl/traffic_req_gen.sv
// Sensor front end for the left-turn traffic light controller: four filtered
// lanes, a shared max-green timer and registered traffic-present flags.
module traffic_req_gen
    import traffic_req_gen_pkg::*;
#(
    parameter int unsigned DB_CYC  = 4,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned MAX_GRN = 32,
    parameter int unsigned CW      = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] det,
    input  logic [2:0] state,
    output logic       Ta,
    output logic       Tal,
    output logic       Tb,
    output logic       Tbl
);

    localparam logic [CW-1:0] MAX_LOAD = CW'(MAX_GRN);

    logic [NUM_LANES-1:0] pres;
    logic [NUM_LANES-1:0] forceoff;
    logic [NUM_LANES-1:0] t_reg;
    logic [2:0]           prev_state_reg;
    logic [CW-1:0]        grn_timer_reg;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lane_filter #(
            .DB_CYC  (DB_CYC),
            .GAP_CYC (GAP_CYC),
            .CW      (CW)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .det     (det[gi]),
            .pres    (pres[gi])
        );

        // A lane is forced off while it is green and has used up its time.
        assign forceoff[gi] = (state == green_code(gi)) && (grn_timer_reg == MAX_LOAD);
    end

    // Remember the previous controller state to detect entry into a green.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_state_reg <= 3'b000;
        else          prev_state_reg <= state;
    end

    // Count cycles spent in the current green; restart on any change or in yellow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                      grn_timer_reg <= '0;
        else if ((state != prev_state_reg) || is_yellow(state)) grn_timer_reg <= '0;
        else if (grn_timer_reg != MAX_LOAD)                grn_timer_reg <= grn_timer_reg + 1'b1;
    end

    // Registered traffic-present flags with max-green force-off applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) t_reg <= '0;
        else          t_reg <= pres & ~forceoff;
    end

    assign Ta  = t_reg[LANE_A];
    assign Tal = t_reg[LANE_AL];
    assign Tb  = t_reg[LANE_B];
    assign Tbl = t_reg[LANE_BL];

endmodule

// File: tb/tb_traffic_req_gen.sv
// Self-checking bench for traffic_req_gen: directed scenarios plus random
// detector/state traffic, compared every cycle against a behavioural model.
module tb_traffic_req_gen;

    localparam int DB   = 4;
    localparam int GAP  = 8;
    localparam int MAXG = 32;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] det;
    logic [2:0] state;
    logic       Ta, Tal, Tb, Tbl;
    logic [3:0] t_vec;

    int checks   = 0;
    int failures = 0;

    // Model: delayed samples, debounced level, length of the current
    // disagreeing run, edges since last fall, and age of the current state.
    logic [3:0] m_sync1, m_s, m_deb, exp_t;
    int         m_run   [4];
    int         m_since [4];
    logic [2:0] m_prev;
    int         m_age;

    traffic_req_gen #(
        .DB_CYC  (DB),
        .GAP_CYC (GAP),
        .MAX_GRN (MAXG),
        .CW      (6)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .det     (det),
        .state   (state),
        .Ta      (Ta),
        .Tal     (Tal),
        .Tb      (Tb),
        .Tbl     (Tbl)
    );

    always #5 clk = ~clk;
    assign t_vec = {Tbl, Tb, Tal, Ta};

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_sync1 = '0; m_s = '0; m_deb = '0; exp_t = '0;
        m_prev = 3'b000; m_age = 0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
            m_since[i] = GAP;
        end
    endtask

    // Advance the model by one rising edge using the pre-edge inputs.
    task automatic model_step();
        logic [3:0] nxt;
        if (!reset_n) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            logic pres_m, forced;
            pres_m = m_deb[i] || (m_since[i] < GAP);
            forced = (int'(state) == 2 * i) && (m_age == MAXG);
            nxt[i] = pres_m && !forced;
        end
        for (int i = 0; i < 4; i++) begin
            logic changed;
            changed = 1'b0;
            if (m_s[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_deb[i]   = m_s[i];
                    m_run[i]   = 0;
                    m_since[i] = m_s[i] ? GAP : 0;
                    changed    = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            if (!changed && m_since[i] < GAP) m_since[i]++;
        end
        m_s     = m_sync1;
        m_sync1 = det;
        if (state != m_prev || state[0]) m_age = 0;
        else if (m_age < MAXG)           m_age++;
        m_prev = state;
        exp_t  = nxt;
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("model_T%0d", i), t_vec[i], exp_t[i]);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("%s_async_T%0d", tag, i), t_vec[i], 1'b0);
        cycles(2);
    endtask

    initial begin
        reset_n = 1'b0; det = '0; state = 3'b000;
        model_clear();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) chk($sformatf("reset_T%0d", i), t_vec[i], 1'b0);

        // Debounce rise on A.
        reset_n = 1'b1; det = 4'b0001; state = 3'b000;
        cycles(6);
        chk("rise_edge6_Ta", Ta, 1'b0);
        cycle();
        chk("rise_edge7_Ta", Ta, 1'b1);
        chk("rise_edge7_Tal", Tal, 1'b0);
        chk("rise_edge7_Tb", Tb, 1'b0);
        chk("rise_edge7_Tbl", Tbl, 1'b0);
        state = 3'b001;
        cycles(4);

        // Glitch rejection on B: 3-cycle pulse ignored, 4-cycle pulse accepted.
        det = 4'b0101; cycles(3);
        det = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk("glitch3_Tb", Tb, 1'b0);
        end
        det = 4'b0101; cycles(4);
        det = 4'b0001; cycles(2);
        chk("pulse4_edge6_Tb", Tb, 1'b0);
        cycle();
        chk("pulse4_edge7_Tb", Tb, 1'b1);
        cycles(16);
        chk("pulse4_done_Tb", Tb, 1'b0);

        // Gap extension: A drops for 5 cycles, flag never falls.
        det = 4'b0000; cycles(5);
        det = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("gap_hold_Ta", Ta, 1'b1);
        end

        // Max green on B: entry at edge 1, forced off after edge 1+MAXG+1.
        async_reset("mg");
        reset_n = 1'b1; det = 4'b0100; state = 3'b100;
        cycles(MAXG + 1);
        chk("maxg_edge33_Tb", Tb, 1'b1);
        cycle();
        chk("maxg_edge34_Tb", Tb, 1'b0);
        cycles(3);
        chk("maxg_hold_Tb", Tb, 1'b0);
        state = 3'b101; cycle();
        chk("maxg_yellow_Tb", Tb, 1'b1);
        state = 3'b100; cycle();
        chk("maxg_reentry_Tb", Tb, 1'b1);
        cycles(MAXG);
        chk("maxg_restart_Tb", Tb, 1'b1);
        cycle();
        chk("maxg_restart_off_Tb", Tb, 1'b0);

        // Yellow with all lanes occupied: no force-off anywhere.
        state = 3'b011; det = 4'b1111;
        cycles(MAXG + 5);
        chk("yellow_all_T", t_vec == 4'b1111, 1'b1);

        // Reset in the middle of the gap hold, then recover with all lanes on.
        det = 4'b0000; cycles(DB + 4);
        chk("midgap_T", t_vec == 4'b1111, 1'b1);
        async_reset("gap");
        reset_n = 1'b1; det = 4'b1111;
        cycles(6);
        chk("recover_edge6_T", t_vec == 4'b0000, 1'b1);
        cycle();
        chk("recover_edge7_T", t_vec == 4'b1111, 1'b1);

        // Random detector runs and state changes against the model.
        begin
            int det_hold [4];
            int st_hold;
            for (int i = 0; i < 4; i++) det_hold[i] = 0;
            st_hold = 0;
            for (int k = 0; k < 1500; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if (det_hold[i] == 0) begin
                        det[i] = $urandom_range(0, 1) == 1;
                        det_hold[i] = $urandom_range(1, 14);
                    end
                    det_hold[i]--;
                end
                if (st_hold == 0) begin
                    state = 3'($urandom_range(0, 7));
                    st_hold = $urandom_range(1, 45);
                end
                st_hold--;
                if (k == 700) async_reset("rand");
                reset_n = 1'b1;
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
